// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the core pipeline and pipe_hazard_ctrl.
// The master side is the core: it reports stall sources and hazard operands
// and receives the hold/flush/stall controls and status.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Stall sources and hazard operands from the pipeline
    logic             im_stall;
    logic             dm_stall;
    logic [4:0]       id_r1a;
    logic [4:0]       id_r2a;
    logic             id_use_r1;
    logic             id_use_r2;
    logic [4:0]       ex_rda;
    logic             ex_load;
    logic             ex_pcsel;

    // Barrier controls and status back to the pipeline
    logic             stall_all;
    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_flush;
    logic             redir_pend;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [15:0]      flush_cnt;

    modport master (
        output im_stall, dm_stall, id_r1a, id_r2a, id_use_r1, id_use_r2,
               ex_rda, ex_load, ex_pcsel,
        input  stall_all, pc_hold, ifid_hold, ifid_flush, idex_flush,
               redir_pend, stall_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  im_stall, dm_stall, id_r1a, id_r2a, id_use_r1, id_use_r2,
               ex_rda, ex_load, ex_pcsel,
        output stall_all, pc_hold, ifid_hold, ifid_flush, idex_flush,
               redir_pend, stall_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV32 pipeline.
// Arbitrates AXI freezes, EX redirects and load-use hazards (in that
// priority), remembers redirects that arrive while frozen, counts stall and
// flush events and raises a sticky watchdog error on over-long freezes.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             frz;
    logic             lu;
    logic             pend_live;
    logic             apply_redir;

    logic             stall_all;
    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_flush;

    logic             redir_pend;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [15:0]      flush_cnt;
    logic [WD_W-1:0]  wd;

    assign frz = bus.im_stall | bus.dm_stall;

    // Load-use: EX load writes a non-zero register that ID is about to read.
    assign lu = bus.ex_load && (bus.ex_rda != 5'd0) &&
                ((bus.id_use_r1 && (bus.id_r1a == bus.ex_rda)) ||
                 (bus.id_use_r2 && (bus.id_r2a == bus.ex_rda)));

    // A latched redirect only exists while frozen or in the release cycle,
    // both of which are spent in HOLD.
    assign pend_live = redir_pend && (state == HOLD);

    // State register for the freeze tracker.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state plus prioritized hold/flush decode (freeze > redirect > load-use).
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt   = state;
        stall_all   = 1'b0;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        apply_redir = 1'b0;

        case (state)
            RUN:     if (frz)  state_nxt = HOLD;
            HOLD:    if (!frz) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase

        // Controls are forced quiet while reset is held.
        if (rst_n) begin
            if (frz) begin
                stall_all = 1'b1;
            end else if (bus.ex_pcsel || pend_live) begin
                // The ID instruction is wrong-path, so any load-use is moot.
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                apply_redir = 1'b1;
            end else if (lu) begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    // Pending redirect: captured during a freeze, dropped once applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   redir_pend <= 1'b0;
        else if (frz && bus.ex_pcsel) redir_pend <= 1'b1;
        else if (!frz)                redir_pend <= 1'b0;
    end

    // Saturating performance counters for frozen cycles and applied flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (frz && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (apply_redir && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    // Watchdog: counts consecutive frozen cycles; the error bit rises on the
    // same edge that brings the count to TIMEOUT and then sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd            <= '0;
            stall_timeout <= 1'b0;
        end else if (!frz) begin
            wd <= '0;
        end else begin
            if (wd != WD_MAX)
                wd <= wd + 1'b1;
            if (wd >= WD_MAX - 1'b1)
                stall_timeout <= 1'b1;
        end
    end

    assign bus.stall_all     = stall_all;
    assign bus.pc_hold       = pc_hold;
    assign bus.ifid_hold     = ifid_hold;
    assign bus.ifid_flush    = ifid_flush;
    assign bus.idex_flush    = idex_flush;
    assign bus.redir_pend    = redir_pend;
    assign bus.stall_timeout = stall_timeout;
    assign bus.stall_cnt     = stall_cnt;
    assign bus.flush_cnt     = flush_cnt;

endmodule
